// File: rtl/serial_bus_pkg.sv
// Shared types for the serial slave receive port: FSM states, the latched
// command, and the frame-length helper used to pick which shifter ends a write.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        DSHIFT,
        WR_WAIT,
        RD_WAIT,
        GAP
    } state_e;

    typedef enum logic {
        CMD_RD,
        CMD_WR
    } cmd_e;

    // A write frame carries address and data side by side, so it lasts as long
    // as the wider of the two fields.
    function automatic int max_frame_len(input int addr_w, input int data_w);
        return (addr_w > data_w) ? addr_w : data_w;
    endfunction

endpackage

// File: rtl/serial_slave_rx_port_p_if.sv
// Bus bundle between a serial master and the slave receive port.
interface serial_slave_rx_port_p_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12
);
    logic              m_valid;
    logic              s_ready;
    logic              read_enable;
    logic              write_enable;
    logic [LEN_W-1:0]  burst_len;
    logic              rx_address;
    logic              rx_data;
    logic              m_ready;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              wr_strobe;
    logic              rd_strobe;
    logic [LEN_W-1:0]  beat_cnt;
    logic              busy;
    logic              err;

    modport master (
        output m_valid, read_enable, write_enable, burst_len,
               rx_address, rx_data, m_ready,
        input  s_ready, addr_out, data_out, wr_strobe, rd_strobe,
               beat_cnt, busy, err
    );

    modport slave (
        input  m_valid, read_enable, write_enable, burst_len,
               rx_address, rx_data, m_ready,
        output s_ready, addr_out, data_out, wr_strobe, rd_strobe,
               beat_cnt, busy, err
    );
endinterface

// File: rtl/serial_shift_in.sv
// LSB-first deserialiser. start_i samples bit 0; the following WIDTH-1 cycles
// sample the remaining bits. value_o already includes the bit being sampled,
// so the consumer can capture the full word on the same edge done_o is high.
module serial_shift_in #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] value_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d, idx;
    logic             run_q, run_d, active;

    // Bit index and next shift contents; a start always restarts at index 0.
    always_comb begin
        active  = start_i || run_q;
        idx     = start_i ? '0 : cnt_q;
        done_o  = active && (idx == CW'(WIDTH - 1));
        shift_d = active ? WIDTH'({bit_i, shift_q} >> 1) : shift_q;
        run_d   = done_o ? 1'b0 : active;
        cnt_d   = done_o ? '0 : (active ? idx + 1'b1 : cnt_q);
        value_o = shift_d;
    end

    // Shift register and bit counter; the word is held once complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end
endmodule

// File: rtl/serial_slave_rx_port_p.sv
// Serial slave receive port: deserialises address/data frames after a
// valid/ready handshake and issues registered read/write beat strobes,
// with incrementing bursts, read back-pressure and a post-write gap.
import serial_bus_pkg::*;

module serial_slave_rx_port_p #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 12,
    parameter int GAP_CYCLES = 3
) (
    input logic               clk,
    input logic               reset,
    serial_slave_rx_port_p_if.slave bus
);
    localparam int     WR_FRAME = max_frame_len(ADDR_W, DATA_W);
    localparam int     GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int     GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    // A finished write burst skips the gap entirely when no gap is configured.
    localparam state_e WR_END   = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_e            state_q;
    cmd_e              cmd_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [ADDR_W-1:0] addr_out_q;
    logic [DATA_W-1:0] data_out_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              wr_strobe_q, rd_strobe_q, err_q;

    logic              s_ready, hs, cmd_ok;
    logic              addr_start, data_start;
    logic              addr_done, data_done, shift_done;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] data_hold;
    logic [LEN_W-1:0]  beat_next;

    assign s_ready    = (state_q == IDLE) || (state_q == WR_WAIT);
    assign hs         = bus.m_valid && s_ready;
    assign cmd_ok     = bus.read_enable ^ bus.write_enable;
    assign addr_start = (state_q == IDLE) && hs && cmd_ok;
    assign data_start = (addr_start && bus.write_enable) ||
                        ((state_q == WR_WAIT) && hs);
    // The first-beat frame ends on the longer field for writes, the address for reads.
    assign shift_done = (cmd_q == CMD_WR) ? ((WR_FRAME == ADDR_W) ? addr_done : data_done)
                                          : addr_done;
    assign beat_next  = beat_cnt_q + 1'b1;

    serial_shift_in #(.WIDTH(ADDR_W)) u_addr_shift (
        .clk     (clk),
        .reset   (reset),
        .start_i (addr_start),
        .bit_i   (bus.rx_address),
        .value_o (addr_hold),
        .done_o  (addr_done)
    );

    serial_shift_in #(.WIDTH(DATA_W)) u_data_shift (
        .clk     (clk),
        .reset   (reset),
        .start_i (data_start),
        .bit_i   (bus.rx_data),
        .value_o (data_hold),
        .done_o  (data_done)
    );

    // Control FSM with registered beat outputs; strobes and err are single-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_RD;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            gap_cnt_q   <= '0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        if (cmd_ok) begin
                            cmd_q      <= bus.write_enable ? CMD_WR : CMD_RD;
                            len_q      <= bus.burst_len;
                            beat_cnt_q <= '0;
                            state_q    <= SHIFT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        addr_out_q <= addr_hold;
                        beat_cnt_q <= '0;
                        gap_cnt_q  <= '0;
                        if (cmd_q == CMD_WR) begin
                            data_out_q  <= data_hold;
                            wr_strobe_q <= 1'b1;
                            state_q     <= (len_q == '0) ? WR_END : WR_WAIT;
                        end else begin
                            rd_strobe_q <= 1'b1;
                            state_q     <= (len_q == '0) ? IDLE : RD_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (hs) begin
                        state_q <= DSHIFT;
                    end
                end
                DSHIFT: begin
                    if (data_done) begin
                        data_out_q  <= data_hold;
                        addr_out_q  <= addr_out_q + 1'b1;
                        beat_cnt_q  <= beat_next;
                        wr_strobe_q <= 1'b1;
                        gap_cnt_q   <= '0;
                        state_q     <= (beat_next == len_q) ? WR_END : WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.m_ready) begin
                        addr_out_q  <= addr_out_q + 1'b1;
                        beat_cnt_q  <= beat_next;
                        rd_strobe_q <= 1'b1;
                        if (beat_next == len_q) begin
                            state_q <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GW'(GAP_LAST)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.addr_out  = addr_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.rd_strobe = rd_strobe_q;
    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
endmodule

// File: doc/serial_slave_rx_port_p.md
Name: serial_slave_rx_port_p

Overview:
- Parametrised next-generation serial slave receive port for the serial bus.
- Deserialises an LSB-first address stream on rx_address and a data stream on rx_data after a valid/ready handshake, then issues registered read/write strobes to the slave memory side.
- Supports configurable address/data/burst widths, incrementing bursts with modulo-2^ADDR_W wrap, m_ready back-pressure on read bursts, a post-write gap, and command error detection.

Parameters:
- ADDR_W, 12, address bits per frame
- DATA_W, 8, data bits per write beat
- LEN_W, 12, burst length field width; value = beats-1, so 0 means single beat
- GAP_CYCLES, 3, s_ready-low cycles after the final write beat

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m_valid  in  1  master request valid
- s_ready  out  1  port ready to accept a handshake
- read_enable  in  1  read command, sampled at the first handshake
- write_enable  in  1  write command, sampled at the first handshake
- burst_len  in  LEN_W  beats-1, sampled at the first handshake
- rx_address  in  1  serial address bit
- rx_data  in  1  serial data bit
- m_ready  in  1  downstream ready for the next read beat
- addr_out  out  ADDR_W  registered beat address
- data_out  out  DATA_W  registered beat write data
- wr_strobe  out  1  one-cycle write pulse
- rd_strobe  out  1  one-cycle read pulse
- beat_cnt  out  LEN_W  beats issued in the current burst
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle command error pulse

Behaviour:
- Reset: state=IDLE; addr_out=0, data_out=0, beat_cnt=0, wr_strobe=0, rd_strobe=0, err=0, busy=0; s_ready=1 after reset release.
- Handshake is the cycle where m_valid && s_ready. s_ready is combinational: 1 in IDLE and WR_WAIT, 0 in all other states.
- Bit i of a frame is sampled i cycles after the handshake, so bit 0 is sampled on the handshake cycle itself. m_valid is ignored during shifting.
- IDLE, on handshake:
  - read_enable=write_enable=1, or both 0: err pulses the next cycle; state stays IDLE.
  - Otherwise latch the command and burst_len, clear beat_cnt, go to SHIFT.
- SHIFT:
  - Shift the address into a hold register for ADDR_W bits.
  - On writes, shift data into a hold register for DATA_W bits concurrently.
  - Frame length N = ADDR_W for a read, max(ADDR_W, DATA_W) for a write.
  - In the cycle after the last bit: addr_out and data_out load from the hold registers, the strobe pulses, and beat_cnt is 0 for this first beat.
  - Strobe latency = N cycles after the handshake.
- After any strobe, if beat_cnt == latched burst_len, the burst is done:
  - write: go to GAP;
  - read: go to IDLE.
- WR_WAIT (write burst, more beats pending):
  - s_ready=1; a handshake starts a DATA_W-bit data-only shift (DSHIFT); rx_address is ignored.
  - In the cycle after the last bit: data_out updates, addr_out <= addr_out+1 (wraps modulo 2^ADDR_W), beat_cnt+1, wr_strobe pulses.
- RD_WAIT (read burst, more beats pending):
  - A cycle with m_ready=1 causes the next cycle to have addr_out+1 (wrapping), beat_cnt+1, rd_strobe=1.
  - m_ready=0 holds state indefinitely. The first read beat never waits for m_ready.
- GAP: count GAP_CYCLES cycles with s_ready=0, then go to IDLE. GAP_CYCLES=0 goes straight to IDLE.
- addr_out and data_out change only on strobe cycles; data_out is unchanged by reads.
- wr_strobe and rd_strobe are never high together.
- burst_len=2^LEN_W-1 is legal. beat_cnt never exceeds the latched burst_len.
- Reset asserted mid-frame aborts immediately to reset values; no strobe is issued.
- Input changes in non-accepting states are ignored; command and burst_len are re-sampled only in IDLE.

Decomposition:
- Package serial_bus_pkg holds:
  - the state enum (IDLE, SHIFT, DSHIFT, WR_WAIT, RD_WAIT, GAP);
  - a command enum (CMD_RD, CMD_WR);
  - a function for the max frame length.
- One sub-module, serial_shift_in (parametrised WIDTH): bit counter, LSB-first shift register, done pulse. It is instanced twice, once for address and once for data.

Test Plan:
- Single write, ADDR_W=12, DATA_W=8: handshake with addr=0x5A3 and data=0xC6 serialised -> wr_strobe exactly 12 cycles after the handshake, addr_out=0x5A3, data_out=0xC6; then s_ready low for 3 cycles.
- Write burst, burst_len=2, addr=0xFFF: three beats with data 0x11, 0x22, 0x33 -> addr_out 0xFFF, 0x000, 0x001 (wrap), beat_cnt 0, 1, 2, then GAP.
- Read burst, burst_len=3, addr=0x010, m_ready held 0 for 5 cycles after the first beat -> no rd_strobe during the stall; rd_strobe at 0x010, 0x011, 0x012, 0x013; data_out unchanged.
- Handshake with read_enable=write_enable=1 -> single err pulse, no strobe, s_ready stays 1.
- Reset asserted at bit 6 of a write frame -> all outputs at reset values, no strobe; a new frame afterwards completes normally.
- DATA_W=16, ADDR_W=8 write -> strobe latency 16 cycles; both fields correct.
